// File: rtl/stack_operand_fetch_pkg.sv
// Shared state encodings and types for the stack operand fetch block.
// The FETCH_* defines keep the encodings visible next to the control-unit state defines.
`ifndef STACK_OPERAND_FETCH_DEFS
`define STACK_OPERAND_FETCH_DEFS
`define FETCH_IDLE  3'd0
`define FETCH_POP_A 3'd1
`define FETCH_POP_B 3'd2
`define FETCH_DONE  3'd3
`define FETCH_ERR   3'd4
`endif

package stack_operand_fetch_pkg;

   localparam int unsigned FETCH_STATE_W = 3;

   typedef enum logic [FETCH_STATE_W-1:0] {
      ST_IDLE  = `FETCH_IDLE,
      ST_POP_A = `FETCH_POP_A,
      ST_POP_B = `FETCH_POP_B,
      ST_DONE  = `FETCH_DONE,
      ST_ERR   = `FETCH_ERR
   } fetch_state_e;

endpackage

// File: rtl/stack_operand_fetch.sv
// Pops one or two operands off the data stack into registered ALU inputs in1/in2.
// Optional FETCH_STICKY_ERR_EN adds a sticky underflow flag that blocks new fetches until cleared.
module stack_operand_fetch
   import stack_operand_fetch_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_req,
   input  logic             fetch_two,
   output logic             fetch_busy,
   output logic             fetch_done,
   output logic             underflow,
   output logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] in2,
   output logic             stk_pop,
   input  logic [WIDTH-1:0] stk_tos,
   input  logic             stk_empty
`ifdef FETCH_STICKY_ERR_EN
   ,
   input  logic             err_clr,
   output logic             err_sticky
`endif
);

   fetch_state_e     state_q, state_d;
   logic             two_q, two_d;
   logic [WIDTH-1:0] in1_q, in1_d;
   logic [WIDTH-1:0] in2_q, in2_d;
   logic             accept_ok;

`ifdef FETCH_STICKY_ERR_EN
   logic err_sticky_q, err_sticky_d;

   // Clear has priority so software can always recover, even on an underflow cycle.
   always_comb begin
      err_sticky_d = err_sticky_q;
      if (err_clr) begin
         err_sticky_d = 1'b0;
      end else if (state_q == ST_ERR) begin
         err_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_sticky_q <= 1'b0;
      end else begin
         err_sticky_q <= err_sticky_d;
      end
   end

   assign err_sticky = err_sticky_q;
   assign accept_ok  = !err_sticky_q;
`else
   assign accept_ok  = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      two_d      = two_q;
      in1_d      = in1_q;
      in2_d      = in2_q;
      stk_pop    = 1'b0;
      fetch_busy = 1'b0;
      fetch_done = 1'b0;
      underflow  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fetch_req && accept_ok) begin
               two_d   = fetch_two;
               state_d = ST_POP_A;
            end
         end
         ST_POP_A: begin
            fetch_busy = 1'b1;
            if (stk_empty) begin
               state_d = ST_ERR;
            end else begin
               stk_pop = 1'b1;
               // The first pop yields TOS, which is the second operand of a binary op.
               if (two_q) begin
                  in2_d   = stk_tos;
                  state_d = ST_POP_B;
               end else begin
                  in1_d   = stk_tos;
                  in2_d   = '0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_POP_B: begin
            fetch_busy = 1'b1;
            if (stk_empty) begin
               state_d = ST_ERR;
            end else begin
               stk_pop = 1'b1;
               in1_d   = stk_tos;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            fetch_done = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_ERR: begin
            underflow = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         two_q   <= 1'b0;
         in1_q   <= '0;
         in2_q   <= '0;
      end else begin
         state_q <= state_d;
         two_q   <= two_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
      end
   end

   assign in1 = in1_q;
   assign in2 = in2_q;

endmodule
